// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline stall controller
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } ctrl_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic en;
        logic flush;
    } stage_ctrl_t;

endpackage

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// rtl/pipe_stall_ctrl_hazard_detect.sv - combinational load-use hazard compare between ID and EX
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [4:0] ex_dst,
    input  logic       ex_reg_write,
    input  logic       ex_mem_to_reg,
    output logic       lu_stall
);

    logic w_dst_match;
    logic w_is_load;

    // r0 is hardwired, so a load targeting it never creates a real dependency
    assign w_dst_match = (ex_dst != REG_ZERO) && ((ex_dst == id_rs) || (ex_dst == id_rt));
    assign w_is_load   = ex_mem_to_reg && ex_reg_write;
    assign lu_stall    = w_is_load && w_dst_match;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline latch enable/flush control with memory watchdog and stall counter
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       ex_dst,
    input  logic             ex_reg_write,
    input  logic             ex_mem_to_reg,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_m_en,
    output logic             m_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             m_wb_bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int              WAIT_W    = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    ctrl_state_e       r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_mem_err;
    logic [CNT_W-1:0]  r_stall_cycles;

    logic        w_lu_stall;
    logic        w_mem_stall;
    logic        w_pc_en;
    logic        w_ex_m_en;
    stage_ctrl_t w_if_id;
    stage_ctrl_t w_id_ex;
    stage_ctrl_t w_m_wb;

    hazard_detect u_hazard_detect (
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .ex_dst        (ex_dst),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .lu_stall      (w_lu_stall)
    );

    assign w_mem_stall = ((r_state == MEM_WAIT) && !mem_ack) ||
                         ((r_state == RUN) && mem_req && !mem_ack);

    // An ack in MEM_WAIT falls through to branch/load-use evaluation: EX was frozen while waiting
    always_comb begin
        w_pc_en   = 1'b1;
        w_ex_m_en = 1'b1;
        w_if_id   = '{en: 1'b1, flush: 1'b0};
        w_id_ex   = '{en: 1'b1, flush: 1'b0};
        w_m_wb    = '{en: 1'b1, flush: 1'b0};
        if (!rst) begin
            w_pc_en   = 1'b0;
            w_ex_m_en = 1'b0;
            w_if_id   = '{en: 1'b0, flush: 1'b1};
            w_id_ex   = '{en: 1'b0, flush: 1'b1};
            w_m_wb    = '{en: 1'b0, flush: 1'b1};
        end else if (r_state == ERROR) begin
            w_pc_en   = 1'b0;
            w_ex_m_en = 1'b0;
            w_if_id   = '{en: 1'b0, flush: 1'b0};
            w_id_ex   = '{en: 1'b0, flush: 1'b0};
            w_m_wb    = '{en: 1'b0, flush: 1'b1};
        end else if (w_mem_stall) begin
            w_pc_en   = 1'b0;
            w_ex_m_en = 1'b0;
            w_if_id   = '{en: 1'b0, flush: 1'b0};
            w_id_ex   = '{en: 1'b0, flush: 1'b0};
            w_m_wb    = '{en: 1'b1, flush: 1'b1};
        end else if (branch_taken) begin
            w_if_id.flush = 1'b1;
            w_id_ex.flush = 1'b1;
        end else if (w_lu_stall) begin
            w_pc_en       = 1'b0;
            w_if_id.en    = 1'b0;
            w_id_ex.flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= RUN;
            r_wait_cnt     <= '0;
            r_mem_err      <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (mem_req && !mem_ack) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= WAIT_ONE;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack) begin
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_state   <= ERROR;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_ONE;
                    end
                end
                ERROR: begin
                    r_state <= ERROR;
                end
                default: begin
                    r_state    <= RUN;
                    r_wait_cnt <= '0;
                end
            endcase
            if (!w_pc_en && !(&r_stall_cycles)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
        end
    end

    assign pc_en        = w_pc_en;
    assign if_id_en     = w_if_id.en;
    assign id_ex_en     = w_id_ex.en;
    assign ex_m_en      = w_ex_m_en;
    assign m_wb_en      = w_m_wb.en;
    assign if_id_flush  = w_if_id.flush;
    assign id_ex_flush  = w_id_ex.flush;
    assign m_wb_bubble  = w_m_wb.flush;
    assign mem_err      = r_mem_err;
    assign stall_cycles = r_stall_cycles;

endmodule
